// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles the signals exchanged between the fetch stage and its neighbours:
//   the program counter / loader side (master) and the fetch stage (slave).
//
//   master drives : pc, jumpFlag, load_we, load_addr, load_data
//   master reads  : instr, instr_pc, instr_valid, done, fetch_count
//   slave is the mirror image of master.
// -----------------------------------------------------------------------------
interface fetch_unit_if #(
    parameter int PC_BITS    = 12,
    parameter int INSTR_BITS = 9,
    parameter int CNT_BITS   = 16
);
    logic [PC_BITS-1:0]    pc;
    logic                  jumpFlag;
    logic                  load_we;
    logic [PC_BITS-1:0]    load_addr;
    logic [INSTR_BITS-1:0] load_data;
    logic [INSTR_BITS-1:0] instr;
    logic [PC_BITS-1:0]    instr_pc;
    logic                  instr_valid;
    logic                  done;
    logic [CNT_BITS-1:0]   fetch_count;

    modport master (
        output pc, jumpFlag, load_we, load_addr, load_data,
        input  instr, instr_pc, instr_valid, done, fetch_count
    );

    modport slave (
        input  pc, jumpFlag, load_we, load_addr, load_data,
        output instr, instr_pc, instr_valid, done, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage. Holds the instruction memory (loadable only while
//   start is high), registers mem[pc] each cycle for the decoder, squashes the
//   wrong-path word fetched in a taken-jump cycle, stops on the halt word and
//   counts delivered (valid) instructions with a saturating counter.
//
//   clock : single clock, all state on posedge
//   start : synchronous active-high reset and program-load window
//   bus   : fetch_unit_if.slave
//           in  pc, jumpFlag, load_we, load_addr, load_data
//           out instr, instr_pc, instr_valid, done, fetch_count
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                    PC_BITS    = 12,
    parameter int                    INSTR_BITS = 9,
    parameter logic [INSTR_BITS-1:0] HALT_INSTR = 9'h1FF,
    parameter int                    CNT_BITS   = 16
) (
    input  logic         clock,
    input  logic         start,
    fetch_unit_if.slave  bus
);
    localparam int DEPTH = 1 << PC_BITS;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [INSTR_BITS-1:0] mem [DEPTH];

    logic [INSTR_BITS-1:0] instr_q, instr_d;
    logic [PC_BITS-1:0]    instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  done_q, done_d;
    logic [CNT_BITS-1:0]   fetch_count_q, fetch_count_d;

    logic [INSTR_BITS-1:0] rd_word;
    logic                  capture_valid;
    logic                  halt_hit;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == {CNT_BITS{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Program load: writes only inside the start window, otherwise ignored.
    always_ff @(posedge clock) begin
        if (start && bus.load_we) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    // pc is exactly PC_BITS wide, so a wrapped pc simply reads mod DEPTH.
    assign rd_word = mem[bus.pc];

    // The edge leaving LOAD always delivers mem[0] as valid; in RUN the word
    // captured during a taken-jump cycle is the sequential one and is squashed.
    always_comb begin
        capture_valid = 1'b0;
        if (state_q == S_LOAD) begin
            capture_valid = 1'b1;
        end else if (state_q == S_RUN) begin
            capture_valid = ~bus.jumpFlag;
        end
    end

    assign halt_hit = capture_valid && (rd_word == HALT_INSTR);

    // State register
    always_ff @(posedge clock) begin
        if (start) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:   state_d = halt_hit ? S_HALTED : S_RUN;
            S_RUN:    state_d = halt_hit ? S_HALTED : S_RUN;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_LOAD;
        endcase
    end

    // Output logic: next values of the registered fetch outputs
    always_comb begin
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = 1'b0;
        done_d        = done_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            S_LOAD, S_RUN: begin
                instr_d       = rd_word;
                instr_pc_d    = bus.pc;
                instr_valid_d = capture_valid;
                done_d        = halt_hit;
                if (capture_valid) begin
                    fetch_count_d = sat_inc(fetch_count_q);
                end
            end
            S_HALTED: begin
                // Everything frozen, nothing delivered, done held.
                done_d = 1'b1;
            end
            default: begin
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (start) begin
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            done_q        <= done_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.done        = done_q;
    assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Drives two fetch_unit instances from one stimulus stream: one with the
//   default 16-bit counter, one with a 3-bit counter to exercise saturation.
//   A behavioural model (array memory, halted/loading flags, integer count)
//   predicts the outputs; directed literal checks pin the model, then a
//   randomized phase runs against it.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
    localparam int PC_BITS    = 12;
    localparam int INSTR_BITS = 9;
    localparam logic [8:0] HALT = 9'h1FF;

    logic clock = 1'b0;
    logic start_r = 1'b1;
    logic [11:0] pc_r = '0;
    logic        jf_r = 1'b0;
    logic        we_r = 1'b0;
    logic [11:0] addr_r = '0;
    logic [8:0]  data_r = '0;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    fetch_unit_if #(.PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS), .CNT_BITS(16)) bus ();
    fetch_unit_if #(.PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS), .CNT_BITS(3))  bus_s ();

    assign bus.pc = pc_r;          assign bus_s.pc = pc_r;
    assign bus.jumpFlag = jf_r;    assign bus_s.jumpFlag = jf_r;
    assign bus.load_we = we_r;     assign bus_s.load_we = we_r;
    assign bus.load_addr = addr_r; assign bus_s.load_addr = addr_r;
    assign bus.load_data = data_r; assign bus_s.load_data = data_r;

    fetch_unit #(.PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS), .HALT_INSTR(HALT), .CNT_BITS(16)) dut (
        .clock(clock), .start(start_r), .bus(bus.slave));
    fetch_unit #(.PC_BITS(PC_BITS), .INSTR_BITS(INSTR_BITS), .HALT_INSTR(HALT), .CNT_BITS(3)) dut_s (
        .clock(clock), .start(start_r), .bus(bus_s.slave));

    // ---------------- behavioural model ----------------
    logic [8:0]  mem_m [4096];
    logic [8:0]  m_instr = '0;
    logic [11:0] m_ipc = '0;
    bit          m_valid = 0;
    bit          m_done = 0;
    int          m_cnt = 0;
    bit          m_loading = 1;
    bit          m_halted = 0;

    always @(posedge clock) begin
        logic [8:0] w;
        bit take;
        if (start_r) begin
            if (we_r) mem_m[addr_r] = data_r;
            m_loading = 1; m_halted = 0;
            m_instr = '0; m_ipc = '0; m_valid = 0; m_done = 0; m_cnt = 0;
        end else if (m_halted) begin
            m_valid = 0;
        end else begin
            w = mem_m[pc_r];
            take = m_loading || !jf_r;
            m_instr = w;
            m_ipc = pc_r;
            m_valid = take;
            if (take) m_cnt++;
            if (take && w == HALT) begin
                m_done = 1;
                m_halted = 1;
            end
            m_loading = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("instr",        32'(bus.instr),        32'(m_instr));
            chk("instr_pc",     32'(bus.instr_pc),     32'(m_ipc));
            chk("instr_valid",  32'(bus.instr_valid),  32'(m_valid));
            chk("done",         32'(bus.done),         32'(m_done));
            chk("fetch_count",  32'(bus.fetch_count),  32'((m_cnt > 65535) ? 65535 : m_cnt));
            chk("fetch_count3", 32'(bus_s.fetch_count), 32'((m_cnt > 7) ? 7 : m_cnt));
            chk("valid3",       32'(bus_s.instr_valid), 32'(m_valid));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [11:0] p, input logic j);
        pc_r = p;
        jf_r = j;
        @(negedge clock);
    endtask

    task automatic load(input logic [11:0] a, input logic [8:0] d);
        start_r = 1'b1;
        we_r = 1'b1;
        addr_r = a;
        data_r = d;
        @(negedge clock);
        we_r = 1'b0;
    endtask

    function automatic logic [11:0] rand_pc();
        return ($urandom % 16 == 0) ? 12'hFFF : 12'($urandom_range(0, 63));
    endfunction

    function automatic logic [8:0] rand_word();
        return ($urandom % 6 == 0) ? HALT : 9'($urandom_range(0, 510));
    endfunction

    initial begin
        @(negedge clock);
        chk_en = 1'b1;
        chk("rst_instr", 32'(bus.instr), 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_done",  32'(bus.done), 32'h0);
        chk("rst_count", 32'(bus.fetch_count), 32'h0);

        // Fill every address the bench will ever fetch.
        for (int i = 0; i < 64; i++) load(12'(i), 9'(i));
        load(12'hFFF, 9'h0EE);
        load(12'd0, 9'h011); load(12'd1, 9'h022); load(12'd2, 9'h033); load(12'd3, 9'h1FF);

        // Straight-line run to halt
        start_r = 1'b0;
        step(12'd0, 1'b0); chk("sl_i0", 32'(bus.instr), 32'h011); chk("sl_v0", 32'(bus.instr_valid), 32'h1);
        step(12'd1, 1'b0); chk("sl_i1", 32'(bus.instr), 32'h022);
        step(12'd2, 1'b0); chk("sl_i2", 32'(bus.instr), 32'h033);
        step(12'd3, 1'b0); chk("sl_i3", 32'(bus.instr), 32'h1FF); chk("sl_done", 32'(bus.done), 32'h1);
        chk("sl_cnt", 32'(bus.fetch_count), 32'd4);
        step(12'd4, 1'b0); chk("halt_v", 32'(bus.instr_valid), 32'h0); chk("halt_ipc", 32'(bus.instr_pc), 32'd3);

        // Write attempt outside load window
        we_r = 1'b1; addr_r = 12'd0; data_r = 9'h155;
        step(12'd0, 1'b0);
        we_r = 1'b0;

        // Reload: jump program
        load(12'd3, 9'h044); load(12'd4, 9'h055); load(12'd5, 9'h1FF);
        load(12'd20, 9'h0AA); load(12'd21, 9'h1FF); load(12'd40, 9'h0CC);
        start_r = 1'b0;
        step(12'd0, 1'b0); chk("nowrite_i0", 32'(bus.instr), 32'h011);
        step(12'd1, 1'b0); step(12'd2, 1'b0); step(12'd3, 1'b0); step(12'd4, 1'b0);
        step(12'd5, 1'b1); chk("jb_instr", 32'(bus.instr), 32'h1FF); chk("jb_valid", 32'(bus.instr_valid), 32'h0);
        chk("jb_done", 32'(bus.done), 32'h0);
        step(12'd20, 1'b0); chk("jt_instr", 32'(bus.instr), 32'h0AA); chk("jt_ipc", 32'(bus.instr_pc), 32'd20);
        chk("jt_cnt", 32'(bus.fetch_count), 32'd6);
        step(12'd21, 1'b1); chk("bb1_valid", 32'(bus.instr_valid), 32'h0);
        step(12'd22, 1'b1); chk("bb2_valid", 32'(bus.instr_valid), 32'h0);
        step(12'd40, 1'b0); chk("bb_tgt", 32'(bus.instr), 32'h0CC); chk("bb_cnt", 32'(bus.fetch_count), 32'd7);

        // Mid-run reset
        start_r = 1'b1;
        step(12'd41, 1'b0);
        chk("mr_instr", 32'(bus.instr), 32'h0); chk("mr_ipc", 32'(bus.instr_pc), 32'h0);
        chk("mr_cnt", 32'(bus.fetch_count), 32'h0); chk("mr_valid", 32'(bus.instr_valid), 32'h0);
        start_r = 1'b0;
        step(12'd0, 1'b0); chk("rr_i0", 32'(bus.instr), 32'h011); chk("rr_cnt", 32'(bus.fetch_count), 32'd1);
        step(12'd1, 1'b0); step(12'd2, 1'b0); step(12'd3, 1'b0); step(12'd4, 1'b0);
        step(12'd5, 1'b1); step(12'd20, 1'b0);
        step(12'd0, 1'b0); step(12'd1, 1'b0); step(12'd2, 1'b0);
        chk("sat_big", 32'(bus.fetch_count), 32'd9);
        chk("sat_small", 32'(bus_s.fetch_count), 32'd7);

        // Randomized episodes
        for (int ep = 0; ep < 40; ep++) begin
            start_r = 1'b1;
            step(rand_pc(), 1'b0);
            for (int n = 0; n < int'($urandom_range(0, 4)); n++) load(rand_pc(), rand_word());
            start_r = 1'b0;
            for (int k = 0; k < int'($urandom_range(10, 50)); k++) begin
                we_r = ($urandom % 10 == 0);
                addr_r = rand_pc();
                data_r = rand_word();
                start_r = ($urandom % 60 == 0);
                step(rand_pc(), ($urandom % 4 == 0));
            end
            we_r = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
